alu_unit: RTL

- Execution-side responder to the reservation station's dispatch interface.
- Each cycle it captures one dispatched op (alu_op, Vi, Vj, imm, rd, pc) and computes the RV32I integer, jump or branch result.
- One cycle later it broadcasts the result on the ALU result bus (rs_ready / rs_ROB_id / rs_val), which the RS and LSB snoop and the ROB consumes.
- It also drives branch-resolution fields to the ROB; it is a registered single-stage pipeline with stall and flush.

---
 rtl/alu_unit_pkg.sv | 36 +++
 rtl/alu_unit_if.sv | 29 ++
 rtl/alu_unit_comb.sv | 93 +++++++++
 rtl/alu_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Op-code constants and decode helpers shared by the ALU datapath and the decoder.
package alu_unit_pkg;

  localparam int ALU_OP_USE_IMM = 6;

  typedef enum logic [5:0] {
    ALU_OP_NOP   = 6'd0,
    ALU_OP_ADD   = 6'd1,
    ALU_OP_SUB   = 6'd2,
    ALU_OP_AND   = 6'd3,
    ALU_OP_OR    = 6'd4,
    ALU_OP_XOR   = 6'd5,
    ALU_OP_SLL   = 6'd6,
    ALU_OP_SRL   = 6'd7,
    ALU_OP_SRA   = 6'd8,
    ALU_OP_SLT   = 6'd9,
    ALU_OP_SLTU  = 6'd10,
    ALU_OP_LUI   = 6'd11,
    ALU_OP_AUIPC = 6'd12,
    ALU_OP_JAL   = 6'd13,
    ALU_OP_JALR  = 6'd14,
    ALU_OP_BEQ   = 6'd16,
    ALU_OP_BNE   = 6'd17,
    ALU_OP_BLT   = 6'd18,
    ALU_OP_BGE   = 6'd19,
    ALU_OP_BLTU  = 6'd20,
    ALU_OP_BGEU  = 6'd21
  } alu_code_e;

  // Only ADD and the logic/shift/compare group have an I-type form.
  function automatic logic imm_legal(input logic [5:0] code);
    return (code == 6'(ALU_OP_ADD)) ||
           ((code >= 6'(ALU_OP_AND)) && (code <= 6'(ALU_OP_SLTU)));
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Dispatch inputs from the reservation station and the ALU result/branch bus.
interface alu_unit_if #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 5
);
  logic [6:0]          alu_op;
  logic [XLEN-1:0]     Vi;
  logic [XLEN-1:0]     Vj;
  logic [XLEN-1:0]     imm;
  logic [ROB_ID_W-1:0] rd;
  logic [XLEN-1:0]     pc;

  logic                rs_ready;
  logic [ROB_ID_W-1:0] rs_ROB_id;
  logic [XLEN-1:0]     rs_val;
  logic                br_taken;
  logic [XLEN-1:0]     br_target;
  logic                is_branch;

  modport master (
    output alu_op, Vi, Vj, imm, rd, pc,
    input  rs_ready, rs_ROB_id, rs_val, br_taken, br_target, is_branch
  );

  modport slave (
    input  alu_op, Vi, Vj, imm, rd, pc,
    output rs_ready, rs_ROB_id, rs_val, br_taken, br_target, is_branch
  );
endinterface

// File: rtl/alu_unit_comb.sv
// Purely combinational RV32I integer/jump/branch evaluation for one dispatched op.
module alu_unit_comb
  import alu_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]      alu_op_i,
  input  logic [XLEN-1:0] vi_i,
  input  logic [XLEN-1:0] vj_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] val_o,
  output logic            taken_o,
  output logic [XLEN-1:0] target_o,
  output logic            is_branch_o
);

  logic [5:0]             code;
  logic                   use_imm;
  logic [XLEN-1:0]        opb;
  logic [4:0]             shamt;
  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic signed [XLEN-1:0] vj_s;
  logic [XLEN-1:0]        pc_imm;
  logic [XLEN-1:0]        pc_inc;
  logic [XLEN-1:0]        jalr_sum;

  assign code     = alu_op_i[5:0];
  assign use_imm  = alu_op_i[ALU_OP_USE_IMM];
  assign opb      = use_imm ? imm_i : vj_i;
  assign shamt    = opb[4:0];
  assign a_s      = vi_i;
  assign b_s      = opb;
  assign vj_s     = vj_i;
  assign pc_imm   = pc_i + imm_i;
  assign pc_inc   = pc_i + XLEN'(4);
  assign jalr_sum = vi_i + imm_i;

  always_comb begin
    valid_o     = 1'b1;
    val_o       = '0;
    taken_o     = 1'b0;
    target_o    = '0;
    is_branch_o = 1'b0;
    if (use_imm && !imm_legal(code)) begin
      valid_o = 1'b0;
    end else begin
      case (code)
        ALU_OP_ADD:   val_o = vi_i + opb;
        ALU_OP_SUB:   val_o = vi_i - opb;
        ALU_OP_AND:   val_o = vi_i & opb;
        ALU_OP_OR:    val_o = vi_i | opb;
        ALU_OP_XOR:   val_o = vi_i ^ opb;
        ALU_OP_SLL:   val_o = vi_i << shamt;
        ALU_OP_SRL:   val_o = vi_i >> shamt;
        ALU_OP_SRA:   val_o = a_s >>> shamt;
        ALU_OP_SLT:   val_o = {{(XLEN-1){1'b0}}, (a_s < b_s)};
        ALU_OP_SLTU:  val_o = {{(XLEN-1){1'b0}}, (vi_i < opb)};
        ALU_OP_LUI:   val_o = imm_i;
        ALU_OP_AUIPC: val_o = pc_imm;
        ALU_OP_JAL: begin
          val_o       = pc_inc;
          taken_o     = 1'b1;
          target_o    = pc_imm;
          is_branch_o = 1'b1;
        end
        ALU_OP_JALR: begin
          val_o       = pc_inc;
          taken_o     = 1'b1;
          target_o    = {jalr_sum[XLEN-1:1], 1'b0};
          is_branch_o = 1'b1;
        end
        // Branches always compare Vi against Vj; the target is shown even when not taken.
        ALU_OP_BEQ, ALU_OP_BNE, ALU_OP_BLT, ALU_OP_BGE, ALU_OP_BLTU, ALU_OP_BGEU: begin
          target_o    = pc_imm;
          is_branch_o = 1'b1;
          case (code)
            ALU_OP_BEQ:  taken_o = (vi_i == vj_i);
            ALU_OP_BNE:  taken_o = (vi_i != vj_i);
            ALU_OP_BLT:  taken_o = (a_s < vj_s);
            ALU_OP_BGE:  taken_o = (a_s >= vj_s);
            ALU_OP_BLTU: taken_o = (vi_i < vj_i);
            default:     taken_o = (vi_i >= vj_i);
          endcase
        end
        default: valid_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_unit.sv
// Single-stage registered ALU: evaluates the dispatched op and broadcasts it one cycle later.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int ROB_ID_W = 5,
  parameter int XLEN     = 32
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       rdy_in,
  input  logic       clear_flag,
  alu_unit_if.slave  bus
);

  logic                c_valid;
  logic [XLEN-1:0]     c_val;
  logic                c_taken;
  logic [XLEN-1:0]     c_target;
  logic                c_is_branch;

  logic                vld_p1_d,    vld_p1_q;
  logic [ROB_ID_W-1:0] tag_p1_d,    tag_p1_q;
  logic [XLEN-1:0]     val_p1_d,    val_p1_q;
  logic                taken_p1_d,  taken_p1_q;
  logic [XLEN-1:0]     target_p1_d, target_p1_q;
  logic                br_p1_d,     br_p1_q;

  alu_unit_comb #(.XLEN(XLEN)) u_comb (
    .alu_op_i    (bus.alu_op),
    .vi_i        (bus.Vi),
    .vj_i        (bus.Vj),
    .imm_i       (bus.imm),
    .pc_i        (bus.pc),
    .valid_o     (c_valid),
    .val_o       (c_val),
    .taken_o     (c_taken),
    .target_o    (c_target),
    .is_branch_o (c_is_branch)
  );

  // Flush wins over a valid op; NOPs and flushes both leave an all-zero bus.
  always_comb begin
    vld_p1_d    = 1'b0;
    tag_p1_d    = '0;
    val_p1_d    = '0;
    taken_p1_d  = 1'b0;
    target_p1_d = '0;
    br_p1_d     = 1'b0;
    if (!clear_flag && c_valid) begin
      vld_p1_d    = 1'b1;
      tag_p1_d    = bus.rd;
      val_p1_d    = c_val;
      taken_p1_d  = c_taken;
      target_p1_d = c_target;
      br_p1_d     = c_is_branch;
    end
  end

  // ---- stage p0 -> p1: result register, frozen while rdy_in is low ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_p1_q    <= 1'b0;
      tag_p1_q    <= '0;
      val_p1_q    <= '0;
      taken_p1_q  <= 1'b0;
      target_p1_q <= '0;
      br_p1_q     <= 1'b0;
    end else if (rdy_in) begin
      vld_p1_q    <= vld_p1_d;
      tag_p1_q    <= tag_p1_d;
      val_p1_q    <= val_p1_d;
      taken_p1_q  <= taken_p1_d;
      target_p1_q <= target_p1_d;
      br_p1_q     <= br_p1_d;
    end
  end

  assign bus.rs_ready  = vld_p1_q;
  assign bus.rs_ROB_id = tag_p1_q;
  assign bus.rs_val    = val_p1_q;
  assign bus.br_taken  = taken_p1_q;
  assign bus.br_target = target_p1_q;
  assign bus.is_branch = br_p1_q;

endmodule
